// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
// Defines forwarding selects, the load result-source code and the memory sequencer states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // The Memory stage is younger than Writeback, so it wins; x0 is hardwired zero and never forwarded.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       reg_write_m,
    input logic [4:0] rd_w,
    input logic       reg_write_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs != 5'd0) begin
      if (reg_write_m && (rd_m == rs))
        sel = FWD_MEM;
      else if (reg_write_w && (rd_w == rs))
        sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_if.sv
// Bundle between the pipeline control path and the hazard controller.
// master = pipeline side (drives stage info, receives controls), slave = hazard_unit.
interface hazard_if #(
  parameter int CNT_W = 32
) ();

  logic [4:0]       rs1_d;
  logic [4:0]       rs2_d;
  logic [4:0]       rs1_e;
  logic [4:0]       rs2_e;
  logic [4:0]       rd_e;
  logic [1:0]       res_src_e;
  logic             pc_src_e;
  logic [4:0]       rd_m;
  logic [4:0]       rd_w;
  logic             reg_write_m;
  logic             reg_write_w;
  logic             mem_req_m;
  logic             mem_ready;

  logic [1:0]       fwd_a_e;
  logic [1:0]       fwd_b_e;
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic             flush_w;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic [CNT_W-1:0] loaduse_count;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, res_src_e, pc_src_e,
           rd_m, rd_w, reg_write_m, reg_write_w, mem_req_m, mem_ready,
    input  fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_w, mem_err,
           stall_cycles, flush_count, loaduse_count
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, res_src_e, pc_src_e,
           rd_m, rd_w, reg_write_m, reg_write_w, mem_req_m, mem_ready,
    output fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_w, mem_err,
           stall_cycles, flush_count, loaduse_count
  );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for the hazard controller's performance statistics.
module hazard_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Holds at all-ones instead of wrapping so a long run never reports a small value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: forwarding, load-use stalls, branch flushes and a memory wait sequencer with watchdog.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  hz
);

  localparam int                WCNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t        state;
  logic [WCNT_W-1:0] wait_cnt;
  logic              mem_err_q;
  logic              timeout_hit;
  logic              lw_stall;
  logic              mem_stall;

  assign hz.fwd_a_e = fwd_select(hz.rs1_e, hz.rd_m, hz.reg_write_m, hz.rd_w, hz.reg_write_w);
  assign hz.fwd_b_e = fwd_select(hz.rs2_e, hz.rd_m, hz.reg_write_m, hz.rd_w, hz.reg_write_w);

  // Stall is gated by rst so a reset during a wait releases the pipeline immediately.
  always_comb begin
    timeout_hit = (state == WAIT) && (wait_cnt == WAIT_LAST);
    lw_stall    = (hz.res_src_e == RES_LOAD) && (hz.rd_e != 5'd0) &&
                  ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));
    mem_stall   = ~rst &
                  (((state == IDLE) & hz.mem_req_m & ~hz.mem_ready) |
                   ((state == WAIT) & ~hz.mem_ready & ~timeout_hit));
  end

  // A branch seen during a memory stall is simply held in Execute; its flush fires on the release cycle.
  assign hz.stall_f = lw_stall | mem_stall;
  assign hz.stall_d = lw_stall | mem_stall;
  assign hz.stall_e = mem_stall;
  assign hz.stall_m = mem_stall;
  assign hz.flush_w = mem_stall;
  assign hz.flush_d = hz.pc_src_e & ~mem_stall;
  assign hz.flush_e = (hz.pc_src_e | lw_stall) & ~mem_stall;
  assign hz.mem_err = mem_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hz.mem_req_m && !hz.mem_ready) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (hz.mem_ready) begin
            state <= IDLE;
          end else if (timeout_hit) begin
            state     <= IDLE;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] loaduse_cnt_q;

  hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (lw_stall | mem_stall),
    .count (stall_cnt_q)
  );

  hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hz.pc_src_e & ~mem_stall),
    .count (flush_cnt_q)
  );

  hazard_perf_cnt #(.W(CNT_W)) u_loaduse_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (lw_stall & ~mem_stall),
    .count (loaduse_cnt_q)
  );

  assign hz.stall_cycles  = stall_cnt_q;
  assign hz.flush_count   = flush_cnt_q;
  assign hz.loaduse_count = loaduse_cnt_q;
`else
  assign hz.stall_cycles  = '0;
  assign hz.flush_count   = '0;
  assign hz.loaduse_count = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios then random traffic against a cycle-level model.
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int TO = 8;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_if #(.CNT_W(CW)) hz ();

  hazard_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: an outstanding access and how many cycles it has stalled so far.
  bit m_busy;
  int m_elapsed;
  bit m_err;
  int m_stall_cnt, m_flush_cnt, m_lu_cnt;

  logic [1:0] e_fa, e_fb;
  bit e_lw, e_ms;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    if (hz.reg_write_m && hz.rd_m == rs) return 2'b10;
    if (hz.reg_write_w && hz.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_elapsed = 0; m_err = 0;
    m_stall_cnt = 0; m_flush_cnt = 0; m_lu_cnt = 0;
  endtask

  // An access may stall at most TO cycles in total; the next cycle is the forced release.
  task automatic model_eval();
    e_fa = ref_fwd(hz.rs1_e);
    e_fb = ref_fwd(hz.rs2_e);
    e_lw = (hz.res_src_e == 2'b01) && (hz.rd_e != 0) &&
           (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);
    e_ms = !rst && (m_busy || hz.mem_req_m) && !hz.mem_ready && (m_elapsed < TO);
  endtask

  task automatic model_advance();
    if (e_lw || e_ms) m_stall_cnt = (m_stall_cnt < SAT) ? m_stall_cnt + 1 : SAT;
    if (hz.pc_src_e && !e_ms) m_flush_cnt = (m_flush_cnt < SAT) ? m_flush_cnt + 1 : SAT;
    if (e_lw && !e_ms) m_lu_cnt = (m_lu_cnt < SAT) ? m_lu_cnt + 1 : SAT;
    if (m_busy) begin
      if (hz.mem_ready || m_elapsed == TO) begin
        if (!hz.mem_ready) m_err = 1;
        m_busy = 0;
        m_elapsed = 0;
      end else begin
        m_elapsed++;
      end
    end else if (hz.mem_req_m && !hz.mem_ready) begin
      m_busy = 1;
      m_elapsed = 1;
    end
  endtask

  task automatic checkOutput();
    model_eval();
    chk("fwd_a_e", 32'(hz.fwd_a_e), 32'(e_fa));
    chk("fwd_b_e", 32'(hz.fwd_b_e), 32'(e_fb));
    chk("stall_f", 32'(hz.stall_f), 32'(e_lw | e_ms));
    chk("stall_d", 32'(hz.stall_d), 32'(e_lw | e_ms));
    chk("stall_e", 32'(hz.stall_e), 32'(e_ms));
    chk("stall_m", 32'(hz.stall_m), 32'(e_ms));
    chk("flush_w", 32'(hz.flush_w), 32'(e_ms));
    chk("flush_d", 32'(hz.flush_d), 32'(hz.pc_src_e & !e_ms));
    chk("flush_e", 32'(hz.flush_e), 32'((hz.pc_src_e | e_lw) & !e_ms));
    chk("mem_err", 32'(hz.mem_err), 32'(m_err));
    chk("stall_cycles", 32'(hz.stall_cycles), PERF ? 32'(m_stall_cnt) : 32'd0);
    chk("flush_count", 32'(hz.flush_count), PERF ? 32'(m_flush_cnt) : 32'd0);
    chk("loaduse_count", 32'(hz.loaduse_count), PERF ? 32'(m_lu_cnt) : 32'd0);
  endtask

  task automatic applyStimulus(
    input logic [4:0] rs1_d, input logic [4:0] rs2_d,
    input logic [4:0] rs1_e, input logic [4:0] rs2_e, input logic [4:0] rd_e,
    input logic [1:0] res_src_e, input logic pc_src_e,
    input logic [4:0] rd_m, input logic [4:0] rd_w,
    input logic rw_m, input logic rw_w, input logic req, input logic ready
  );
    hz.rs1_d = rs1_d;  hz.rs2_d = rs2_d;
    hz.rs1_e = rs1_e;  hz.rs2_e = rs2_e;  hz.rd_e = rd_e;
    hz.res_src_e = res_src_e;  hz.pc_src_e = pc_src_e;
    hz.rd_m = rd_m;  hz.rd_w = rd_w;
    hz.reg_write_m = rw_m;  hz.reg_write_w = rw_w;
    hz.mem_req_m = req;  hz.mem_ready = ready;
  endtask

  task automatic idle_inputs();
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cycle();
    #1;
    checkOutput();
    model_advance();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int seen;

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    $display("[TB] forwarding priority");
    applyStimulus(0, 0, 5, 0, 0, 2'b00, 0, 5, 5, 1, 1, 0, 0);
    #1 chk("fwd_mem_prio", 32'(hz.fwd_a_e), 32'(FWD_MEM));
    cycle();
    applyStimulus(0, 0, 5, 0, 0, 2'b00, 0, 5, 5, 0, 1, 0, 0);
    #1 chk("fwd_wb", 32'(hz.fwd_a_e), 32'(FWD_WB));
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0);
    #1 chk("fwd_x0", 32'(hz.fwd_a_e), 32'(FWD_RF));
    cycle();

    $display("[TB] memory wait, same-cycle ready, load-use");
    do_reset();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
      #1 if (hz.stall_e) seen++;
      cycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1);
    #1 if (hz.stall_e) seen++;
    cycle();
    chk("mem_wait_stall_cycles", 32'(seen), 32'd4);
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1);
    #1 chk("same_cycle_ready", 32'(hz.stall_f), 32'd0);
    cycle();
    applyStimulus(0, 3, 0, 0, 3, 2'b01, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("loaduse_stall_d", 32'(hz.stall_d), 32'd1);
    chk("loaduse_stall_e", 32'(hz.stall_e), 32'd0);
    chk("loaduse_flush_e", 32'(hz.flush_e), 32'd1);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("loaduse_x0", 32'(hz.stall_f), 32'd0);
    chk("perf_stall_cycles", 32'(hz.stall_cycles), PERF ? 32'd5 : 32'd0);
    chk("perf_loaduse", 32'(hz.loaduse_count), PERF ? 32'd1 : 32'd0);
    cycle();

    $display("[TB] deferred branch");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 1, 0);
      #1 chk("defer_flush_d", 32'(hz.flush_d), 32'd0);
      cycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 1, 1);
    #1 chk("release_flush_d", 32'(hz.flush_d), 32'd1);
    chk("release_flush_e", 32'(hz.flush_e), 32'd1);
    cycle();

    $display("[TB] watchdog timeout");
    for (int i = 0; i < TO; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
      #1 chk("timeout_stalling", 32'(hz.stall_m), 32'd1);
      cycle();
    end
    #1 chk("timeout_release", 32'(hz.stall_m), 32'd0);
    chk("timeout_err_not_yet", 32'(hz.mem_err), 32'd0);
    cycle();
    idle_inputs();
    #1 chk("timeout_err_set", 32'(hz.mem_err), 32'd1);
    cycle();
    #1 chk("timeout_err_sticky", 32'(hz.mem_err), 32'd1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
      cycle();
    end
    #3 rst = 1'b1;
    #1 chk("rst_mid_wait_stall", 32'(hz.stall_e), 32'd0);
    chk("rst_mid_wait_err", 32'(hz.mem_err), 32'd0);
    model_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    cycle();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(
        5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
        5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
        2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
        5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
        1'($urandom), 1'($urandom),
        1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: bench did not finish, observed time %0t required < 200000", $time);
    $fatal(1, "[TB] bench timeout");
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage RV32I core. It sits beside the decode-stage control unit. It generates operand forwarding selects for Execute, load-use stalls, and branch/jump flushes. It also sequences the Memory stage against a variable-latency data memory through a request/ready handshake with a watchdog timeout. It is the only source of stall and flush signals for the pipeline registers.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before a forced release and error flag.
- CNT_W, 32: width of the performance counters.

Ports:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high (rst).
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- rs1_d, rs2_d  in  5  source registers in Decode.
- rs1_e, rs2_e, rd_e  in  5  source and destination registers in Execute.
- res_src_e  in  2  result source in Execute; 01 = load.
- pc_src_e  in  1  taken branch or jump resolved in Execute.
- rd_m, rd_w  in  5  destination registers in Memory and Writeback.
- reg_write_m, reg_write_w  in  1  register-write enables in Memory and Writeback.
- mem_req_m  in  1  load or store present in Memory.
- mem_ready  in  1  data memory completes the access this cycle.
- fwd_a_e, fwd_b_e  out  2  operand select: 00 = register file, 01 = Writeback result, 10 = Memory ALU result.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the pipeline register of that stage.
- flush_d, flush_e, flush_w  out  1  insert a bubble into that stage.
- mem_err  out  1  sticky timeout error flag.
- stall_cycles, flush_count, loaduse_count  out  CNT_W  performance counters.

## Operation
- **Forwarding:** applied independently per operand.
  - Select 10 if reg_write_m and rd_m == rs_e and rs_e != 0.
  - Otherwise select 01 if reg_write_w and rd_w == rs_e and rs_e != 0.
  - Otherwise select 00.
  - Memory has priority over Writeback. x0 is never forwarded.
- **Load-use:** lw_stall = (res_src_e == 01) & rd_e != 0 & (rd_e == rs1_d | rd_e == rs2_d).
- **Memory sequencer FSM:** two states, IDLE and WAIT.
  - IDLE → WAIT when mem_req_m & ~mem_ready.
  - WAIT → IDLE when mem_ready, or when wait_cnt == TIMEOUT_CYCLES-1. The timeout sets mem_err.
  - wait_cnt is cleared on entering WAIT and increments each WAIT cycle.
- **mem_stall:** (IDLE & mem_req_m & ~mem_ready) | (WAIT & ~mem_ready & ~timeout_hit).
  - A same-cycle mem_ready in IDLE produces zero stall.
- **Output equations:**
  - stall_f = stall_d = lw_stall | mem_stall.
  - stall_e = stall_m = mem_stall.
  - flush_w = mem_stall.
  - flush_d = pc_src_e & ~mem_stall.
  - flush_e = (pc_src_e | lw_stall) & ~mem_stall.
- **Flush deferral:** a branch resolved during a memory stall stays held in Execute. Its flush takes effect on the release cycle.
- **mem_err:** sticky; cleared only by rst.

## Timing
- Forward, stall and flush outputs are combinational from inputs and registered state, valid in the same cycle.
- The FSM, wait_cnt, mem_err and counters update on the clk rising edge.
- **Reset values:**
  - State = IDLE, wait_cnt = 0, mem_err = 0, counters = 0.
  - With all inputs at 0, every output is 0.
- **Reset mid-WAIT:** immediate return to IDLE; the stall drops asynchronously.
- **Timeout:** a WAIT lasting TIMEOUT_CYCLES cycles releases the stall in its final cycle. mem_err is high from the next cycle.
- **Simultaneous load-use and memory stall:** the memory stall dominates and flush_e is suppressed. lw_stall is re-evaluated after release.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with stall_f high.
  - flush_count increments on every cycle with flush_d high.
  - loaduse_count increments on every cycle with lw_stall & ~mem_stall.
  - All three counters saturate at 2^CNT_W-1.
- HAZARD_PERF_CNT_EN undefined: the counter outputs are tied to 0 and no counter flops are built.

## Structure
- Shared package hazard_pkg holds:
  - forwarding encodings FWD_RF, FWD_WB, FWD_MEM;
  - load result-source constant RES_LOAD = 2'b01;
  - the FSM state type (IDLE, WAIT).
- One sub-module, hazard_perf_cnt: a parameterised saturating counter instantiated three times, only under HAZARD_PERF_CNT_EN.

## Test plan
- **Forwarding priority:** rs1_e = 5, rd_m = 5 (reg_write_m = 1), rd_w = 5 (reg_write_w = 1) → fwd_a_e = 10. Drop reg_write_m → 01. Repeat with rs1_e = 0 → 00.
- **Load-use:** res_src_e = 01, rd_e = 3, rs2_d = 3 → stall_f = stall_d = flush_e = 1 for one cycle, stall_e = 0. With rd_e = 0 → no stall.
- **Memory wait:** mem_req_m = 1, mem_ready low for 4 cycles then high → stall_f/d/e/m and flush_w high for exactly 4 cycles, FSM back in IDLE. A same-cycle ready gives 0 stall cycles.
- **Deferred branch:** pc_src_e = 1 during a 3-cycle memory wait → flush_d/flush_e stay 0 during the wait and are asserted on the release cycle.
- **Timeout:** TIMEOUT_CYCLES = 8, mem_ready never asserted → stall released after 8 WAIT cycles, mem_err = 1 and stays set. Asserting rst mid-WAIT clears state and mem_err.
- **Counters (HAZARD_PERF_CNT_EN):** 4-cycle memory stall plus one load-use → stall_cycles = 5, loaduse_count = 1. With CNT_W = 2, the counters hold at 3.
